wave_sequencer: RTL and testbench
=================================

# wave_sequencer

Programmable sequencer for `signal_generator`: it drives `wave_choise` through a stored list of (mode, period-count) steps. Mode changes happen only on waveform period boundaries, so the generator never switches mid-period. The block sits between the register/config side and `signal_generator`, and is its only driver of `wave_choise`. It supports one-shot and looping playback, graceful stop, and per-period tick reporting.

## Interface
- `DEPTH`, 4: number of program slots (≥2).
- `DUR_W`, 8: width of the period-count field per step.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  program-entry write request.
- `cfg_ready`  out  1  entry accepted when `cfg_valid && cfg_ready`.
- `cfg_mode`  in  2  0 square, 1 sawtooth, 2 triangle, 3 off.
- `cfg_periods`  in  DUR_W  periods for this step; 0 is treated as 1.
- `cfg_clear`  in  1  empties the program (IDLE only).
- `start`  in  1  level-sampled; begins playback from slot 0.
- `stop`  in  1  request to end playback at the next period boundary.
- `loop_en`  in  1  after the last slot, wrap to slot 0 instead of finishing.
- `wave_choise`  out  2  mode to `signal_generator`.
- `step_idx`  out  clog2(DEPTH)  current slot.
- `busy`  out  1  high in RUN.
- `period_tick`  out  1  one-cycle pulse on the last cycle of each period.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- **States:** IDLE and RUN.
- **Reset values:** IDLE, `wave_choise`=3, `step_idx`=0, `busy`=0, `period_tick`=0, `done`=0, `cfg_ready`=1, program count=0, phase=0, period counter=0.
- **IDLE, writes:** `cfg_ready` = (count < DEPTH). An accepted write stores into slot[count] and increments count. `cfg_valid` while `cfg_ready`=0 is dropped.
- **IDLE, clear:** `cfg_clear` sets count=0. If `cfg_clear` and `cfg_valid` arrive together, clear wins and the write is dropped.
- **IDLE, start:** `start` with count>0 (including an entry written in the same cycle) moves to RUN. `start` with count=0 is ignored.
- **RUN, outputs:** `cfg_ready`=0, `busy`=1, and `wave_choise`=slot[step_idx].mode.
- **Phase counter:** counts 0..P−1, where P is 20 for square, 21 for sawtooth, 40 for triangle, and 20 for off.
- **End of period:** when phase=P−1, pulse `period_tick`, set phase to 0, and increment the period counter.
- **End of step:** when the period counter reaches the step's count (max(cfg_periods,1)):
  - if step_idx < count−1, advance `step_idx` and reset the period counter;
  - else if `loop_en`, set `step_idx`=0;
  - else go to IDLE with `done` pulsing on that same edge.
- **Stop:** `stop` in RUN sets `stop_pend`. At the next period end, go to IDLE with no `done`. `stop_pend` clears on entry to IDLE. `stop` in IDLE has no effect.
- **On entry to IDLE:** `wave_choise`=3, `step_idx`=0, and the program is retained.
- **Widths:** phase is 6 bits. The period counter is DUR_W bits and cannot overflow because it compares against ≥1. `step_idx` wraps only via `loop_en`.

## Timing
- `start` sampled high at edge N: `busy`=1 and `wave_choise`=slot0 mode from edge N+1. Phase 0 is the cycle after N+1's edge.
- A step of k periods of length P occupies exactly k·P cycles. `period_tick` is high on the cycle where phase=P−1.
- Step transition: the new `wave_choise` appears on the edge after the last cycle of the old step, with no gap cycle.
- Completion: `done` and `busy`=0 and `wave_choise`=3 all appear on the same edge.
- Reset mid-run: reset values take effect on the next edge after `rst_n` is sampled low. The program is lost.
- `loop_en` is sampled at each end-of-step. Deasserting it mid-run ends playback at the end of the current pass through the last slot.

## Structure
- Shared package `signal_gen_pkg`:
  - mode constants MODE_SQUARE=0, MODE_SAW=1, MODE_TRI=2, MODE_OFF=3;
  - period constants PER_SQUARE=20, PER_SAW=21, PER_TRI=40, PER_OFF=20;
  - a function mapping mode to period length.
  - `signal_generator` benches reuse the same package.
- Sub-module `wave_period_counter`: takes mode and enable, outputs phase and `period_end`. The FSM, slot array and step logic stay at top level.

## Test plan
- Load (0,2),(2,1); start → `wave_choise`=0 for 40 cycles, then 2 for 40 cycles, then 3. `done` pulses once. `period_tick` fires at cycles 20, 40, 80 after RUN entry.
- Load (1,0); start → `wave_choise`=1 for exactly 21 cycles, then `done`.
- Load (1,1), `loop_en`=1 → `wave_choise` stays 1, `step_idx` stays 0, `period_tick` every 21 cycles, no `done` over 500 cycles.
- Load (0,3); pulse `stop` at phase 5 of the first period → IDLE after 15 more cycles, `done` stays 0, program retained (a restart replays 60 cycles).
- Write 4 entries, then a 5th with `cfg_ready`=0 → count stays 4. Issue `cfg_clear`, then `start` → remains IDLE, `busy`=0.
- `rst_n` low for 1 cycle mid-triangle step → next edge: `wave_choise`=3, `busy`=0, count=0, `cfg_ready`=1.

Source files
------------

// File: rtl/signal_gen_pkg.sv
// signal_gen_pkg: waveform mode codes, period lengths and sequencer state type
package signal_gen_pkg;
  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;
  localparam logic [5:0] PER_SQUARE  = 6'd20;
  localparam logic [5:0] PER_SAW     = 6'd21;
  localparam logic [5:0] PER_TRI     = 6'd40;
  localparam logic [5:0] PER_OFF     = 6'd20;
  typedef enum logic {S_IDLE, S_RUN} seq_state_t;
  function automatic logic [5:0] period_of(input logic [1:0] mode);
    return mode == MODE_SAW ? PER_SAW :
           mode == MODE_TRI ? PER_TRI :
           mode == MODE_OFF ? PER_OFF : PER_SQUARE;
  endfunction
endpackage

// File: rtl/wave_sequencer_if.sv
// wave_sequencer_if: program-entry write channel of the sequencer
interface wave_sequencer_if #(parameter int DUR_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DUR_W-1:0] cfg_periods;
  logic             cfg_clear;
  modport master (output cfg_valid, cfg_mode, cfg_periods, cfg_clear, input cfg_ready);
  modport slave  (input cfg_valid, cfg_mode, cfg_periods, cfg_clear, output cfg_ready);
endinterface

// File: rtl/wave_period_counter.sv
// wave_period_counter: phase counter that flags the last cycle of each waveform period
module wave_period_counter
  import signal_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  output logic [5:0] phase,
  output logic       period_end
);
  assign period_end = en && phase == period_of(mode) - 6'd1;
  always_ff @(posedge clk)
    phase <= (!rst_n || !en || period_end) ? 6'd0 : phase + 6'd1;
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: steps signal_generator through a stored (mode, periods) program on period boundaries
module wave_sequencer
  import signal_gen_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DUR_W = 8,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  wave_sequencer_if.slave     cfg,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  output logic [1:0]          wave_choise,
  output logic [IW-1:0]       step_idx,
  output logic                busy,
  output logic                period_tick,
  output logic                done
);
  seq_state_t       state, state_n;
  logic [1:0]       mode_q [DEPTH];
  logic [DUR_W-1:0] per_q  [DEPTH];
  logic [CW-1:0]    cnt;
  logic [DUR_W-1:0] pcnt, eff_per;
  logic             stop_pend, accept, last, step_end, period_end, fin;
  logic [5:0]       phase;
  assign cfg.cfg_ready = state == S_IDLE && cnt < CW'(DEPTH);
  assign accept      = cfg.cfg_valid && cfg.cfg_ready && !cfg.cfg_clear;
  assign busy        = state == S_RUN;
  assign wave_choise = busy ? mode_q[step_idx] : MODE_OFF;
  assign period_tick = period_end;
  assign eff_per     = per_q[step_idx] == '0 ? DUR_W'(1) : per_q[step_idx];
  assign step_end    = period_end && pcnt + DUR_W'(1) == eff_per;
  assign last        = CW'(step_idx) == cnt - CW'(1);
  wave_period_counter u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (busy),
    .mode       (wave_choise),
    .phase      (phase),
    .period_end (period_end)
  );
  // a pending stop wins over natural completion at the same boundary, so no done then
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    if (state == S_IDLE)
      state_n = start && !cfg.cfg_clear && (cnt != '0 || accept) ? S_RUN : S_IDLE;
    else begin
      fin     = step_end && last && !loop_en && !stop_pend;
      state_n = (period_end && stop_pend) || fin ? S_IDLE : S_RUN;
    end
  end
  always_ff @(posedge clk)
    if (accept) begin
      mode_q[IW'(cnt)] <= cfg.cfg_mode;
      per_q[IW'(cnt)]  <= cfg.cfg_periods;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      step_idx  <= '0;
      pcnt      <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= fin;
      stop_pend <= state_n == S_RUN && (stop_pend || (busy && stop));
      if (state == S_IDLE)
        cnt <= cfg.cfg_clear ? '0 : accept ? cnt + CW'(1) : cnt;
      if (state_n != S_RUN) begin
        step_idx <= '0;
        pcnt     <= '0;
      end else if (step_end) begin
        step_idx <= last ? '0 : step_idx + IW'(1);
        pcnt     <= '0;
      end else if (period_end)
        pcnt <= pcnt + DUR_W'(1);
    end
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed checks of program load, playback, looping, stop, clear and reset
module tb_wave_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop_en;
  logic [1:0] wave_choise;
  logic [1:0] step_idx;
  logic       busy, period_tick, done;
  int         errors = 0;
  int         checks = 0;
  wave_sequencer_if #(.DUR_W(8)) cfg_if ();
  wave_sequencer #(.DEPTH(4), .DUR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .wave_choise (wave_choise),
    .step_idx    (step_idx),
    .busy        (busy),
    .period_tick (period_tick),
    .done        (done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] m, input logic [7:0] p);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode = m;
    cfg_if.cfg_periods = p;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask
  task automatic clr();
    cfg_if.cfg_clear = 1'b1;
    tick();
    cfg_if.cfg_clear = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = 2'd0; cfg_if.cfg_periods = 8'd0; cfg_if.cfg_clear = 1'b0;
    tick(); tick();
    check("rst_wave", wave_choise, 3);
    check("rst_idx", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", period_tick, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    rst_n = 1'b1;
    tick();
    // two-step one-shot program
    wr(2'd0, 8'd2); wr(2'd2, 8'd1);
    check("t1_ready", cfg_if.cfg_ready, 1);
    go();
    for (int c = 1; c <= 80; c++) begin
      check("t1_wave", wave_choise, c <= 40 ? 0 : 2);
      check("t1_idx", step_idx, c <= 40 ? 0 : 1);
      check("t1_busy", busy, 1);
      check("t1_tick", period_tick, (c == 20 || c == 40 || c == 80) ? 1 : 0);
      check("t1_nodone", done, 0);
      tick();
    end
    check("t1_end_busy", busy, 0);
    check("t1_end_wave", wave_choise, 3);
    check("t1_done", done, 1);
    tick();
    check("t1_done_once", done, 0);
    // zero periods treated as one; write and start in the same cycle
    clr();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd1; cfg_if.cfg_periods = 8'd0; start = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      check("t2_wave", wave_choise, 1);
      check("t2_busy", busy, 1);
      check("t2_tick", period_tick, c == 21 ? 1 : 0);
      tick();
    end
    check("t2_end_busy", busy, 0);
    check("t2_done", done, 1);
    // looping single step, then drop loop_en
    clr();
    wr(2'd1, 8'd1);
    loop_en = 1'b1;
    go();
    for (int c = 1; c <= 500; c++) begin
      check("t3_wave", wave_choise, 1);
      check("t3_idx", step_idx, 0);
      check("t3_tick", period_tick, c % 21 == 0 ? 1 : 0);
      check("t3_nodone", done, 0);
      if (c == 500) loop_en = 1'b0;
      tick();
    end
    for (int c = 501; c <= 504; c++) begin
      check("t3_tail_busy", busy, 1);
      tick();
    end
    check("t3_end_busy", busy, 0);
    check("t3_done", done, 1);
    // graceful stop at phase 5, then restart replays full program
    clr();
    wr(2'd0, 8'd3);
    go();
    for (int c = 1; c <= 20; c++) begin
      check("t4_busy", busy, 1);
      stop = c == 6;
      tick();
    end
    stop = 1'b0;
    check("t4_stopped", busy, 0);
    check("t4_wave", wave_choise, 3);
    check("t4_nodone", done, 0);
    tick();
    check("t4_nodone2", done, 0);
    go();
    for (int c = 1; c <= 60; c++) begin
      check("t4r_wave", wave_choise, 0);
      check("t4r_busy", busy, 1);
      tick();
    end
    check("t4r_done", done, 1);
    // full program, overflow write dropped, then clear beats write
    clr();
    wr(2'd0, 8'd1); wr(2'd1, 8'd1); wr(2'd2, 8'd1);
    check("t5_ready3", cfg_if.cfg_ready, 1);
    wr(2'd3, 8'd1);
    check("t5_ready4", cfg_if.cfg_ready, 0);
    wr(2'd1, 8'd1);
    check("t5_ready5", cfg_if.cfg_ready, 0);
    go();
    for (int c = 1; c <= 101; c++) begin
      check("t5_idx", step_idx, c <= 20 ? 0 : c <= 41 ? 1 : c <= 81 ? 2 : 3);
      check("t5_wave", wave_choise, c <= 20 ? 0 : c <= 41 ? 1 : c <= 81 ? 2 : 3);
      check("t5_ready_run", cfg_if.cfg_ready, 0);
      tick();
    end
    check("t5_done", done, 1);
    check("t5_end_busy", busy, 0);
    cfg_if.cfg_clear = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = 2'd0; cfg_if.cfg_periods = 8'd1;
    tick();
    cfg_if.cfg_clear = 1'b0; cfg_if.cfg_valid = 1'b0;
    check("t5_clr_ready", cfg_if.cfg_ready, 1);
    go();
    check("t5_empty_start", busy, 0);
    tick();
    check("t5_empty_start2", busy, 0);
    // reset in the middle of a triangle step
    wr(2'd2, 8'd2);
    go();
    for (int c = 1; c <= 10; c++) tick();
    check("t6_pre_wave", wave_choise, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_wave", wave_choise, 3);
    check("t6_busy", busy, 0);
    check("t6_ready", cfg_if.cfg_ready, 1);
    check("t6_idx", step_idx, 0);
    go();
    check("t6_prog_lost", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
